// File: rtl/tetris_step_sched.sv
// rtl/tetris_step_sched.sv - tetris step scheduler: gravity/key arbitration and check/commit/lock/spawn sequencing
// Optional feature: define SOFT_DROP_EN to let key_down request an immediate down step and restart gravity.
module tetris_step_sched #(
   parameter int TICK_DIV = 25_000_000
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic       key_left,
   input  logic       key_right,
   input  logic       key_rot,
   input  logic       key_down,
   output logic       chk_req,
   output logic [1:0] chk_op,
   input  logic       chk_done,
   input  logic       chk_ok,
   output logic       commit,
   output logic       lock_req,
   input  logic       lock_done,
   output logic       spawn_req,
   input  logic       spawn_done,
   input  logic       spawn_ok,
   output logic       game_over
);

   localparam int            CW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

   localparam logic [1:0] OP_DOWN  = 2'b00;
   localparam logic [1:0] OP_LEFT  = 2'b01;
   localparam logic [1:0] OP_RIGHT = 2'b10;
   localparam logic [1:0] OP_ROT   = 2'b11;

   typedef enum logic [2:0] {
      S_SPAWN,
      S_READY,
      S_CHECK,
      S_COMMIT,
      S_LOCK,
      S_OVER
   } state_t;

   state_t          state_q;
   logic            chk_req_q, commit_q, lock_req_q, spawn_req_q, game_over_q;
   logic [1:0]      chk_op_q;

   logic [CW-1:0]   cnt_q, cnt_d;
   logic            wrap_q, wrap_d;

   // key_q holds the synchronised level, key_qq the previous one; a rise is key_q & ~key_qq
   logic            left_q, left_qq, right_q, right_qq, rot_q, rot_qq;
   logic            left_rise, right_rise, rot_rise, down_rise;

   logic            tick_pend_q, tick_pend_d;
   logic            left_pend_q, left_pend_d;
   logic            right_pend_q, right_pend_d;
   logic            rot_pend_q, rot_pend_d;

   logic            any_pend;
   logic [1:0]      sel_op;
   logic            leave_ready;
   logic            enter_lock;

   assign left_rise  = left_q  & ~left_qq;
   assign right_rise = right_q & ~right_qq;
   assign rot_rise   = rot_q   & ~rot_qq;

`ifdef SOFT_DROP_EN
   logic            down_q, down_qq;
   assign down_rise = down_q & ~down_qq;

   // soft-drop key synchroniser and edge history
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         down_q  <= 1'b0;
         down_qq <= 1'b0;
      end else begin
         down_q  <= key_down;
         down_qq <= down_q;
      end
   end
`else
   logic            unused_key_down;
   assign unused_key_down = key_down;
   assign down_rise       = 1'b0;
`endif

   // move/rotate key synchronisers and edge history
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         left_q   <= 1'b0;
         left_qq  <= 1'b0;
         right_q  <= 1'b0;
         right_qq <= 1'b0;
         rot_q    <= 1'b0;
         rot_qq   <= 1'b0;
      end else begin
         left_q   <= key_left;
         left_qq  <= left_q;
         right_q  <= key_right;
         right_qq <= right_q;
         rot_q    <= key_rot;
         rot_qq   <= rot_q;
      end
   end

   // gravity counter: free-runs outside OVER, restarts on a soft drop
   always_comb begin
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      if (state_q != S_OVER) begin
         if (cnt_q == CNT_MAX) begin
            cnt_d  = '0;
            wrap_d = 1'b1;
         end else begin
            cnt_d  = cnt_q + CW'(1);
         end
         if (down_rise) begin
            cnt_d  = '0;
         end
      end
   end

   // service selection: down beats rotate beats left beats right
   always_comb begin
      any_pend = tick_pend_q | rot_pend_q | left_pend_q | right_pend_q;
      if (tick_pend_q) begin
         sel_op = OP_DOWN;
      end else if (rot_pend_q) begin
         sel_op = OP_ROT;
      end else if (left_pend_q) begin
         sel_op = OP_LEFT;
      end else begin
         sel_op = OP_RIGHT;
      end
      leave_ready = (state_q == S_READY) && any_pend;
      enter_lock  = (state_q == S_CHECK) && chk_done && !chk_ok && (chk_op_q == OP_DOWN);
   end

   // pend flags: set on events, cleared when serviced (clear wins over a coincident set)
   always_comb begin
      tick_pend_d  = tick_pend_q  | wrap_q | down_rise;
      rot_pend_d   = rot_pend_q   | rot_rise;
      left_pend_d  = left_pend_q  | left_rise;
      right_pend_d = right_pend_q | right_rise;
      if (leave_ready && sel_op == OP_DOWN) begin
         tick_pend_d = 1'b0;
      end
      if ((leave_ready && sel_op == OP_ROT) || enter_lock) begin
         rot_pend_d = 1'b0;
      end
      if ((leave_ready && sel_op == OP_LEFT) || enter_lock) begin
         left_pend_d = 1'b0;
      end
      if ((leave_ready && sel_op == OP_RIGHT) || enter_lock) begin
         right_pend_d = 1'b0;
      end
   end

   // counter, wrap pulse and pend flag registers
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         cnt_q        <= '0;
         wrap_q       <= 1'b0;
         tick_pend_q  <= 1'b0;
         rot_pend_q   <= 1'b0;
         left_pend_q  <= 1'b0;
         right_pend_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         wrap_q       <= wrap_d;
         tick_pend_q  <= tick_pend_d;
         rot_pend_q   <= rot_pend_d;
         left_pend_q  <= left_pend_d;
         right_pend_q <= right_pend_d;
      end
   end

   // step sequencer with registered handshake outputs
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q     <= S_SPAWN;
         chk_req_q   <= 1'b0;
         chk_op_q    <= OP_DOWN;
         commit_q    <= 1'b0;
         lock_req_q  <= 1'b0;
         spawn_req_q <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         case (state_q)
            S_SPAWN: begin
               if (spawn_done) begin
                  spawn_req_q <= 1'b0;
                  if (spawn_ok) begin
                     state_q <= S_READY;
                  end else begin
                     state_q     <= S_OVER;
                     game_over_q <= 1'b1;
                  end
               end else begin
                  spawn_req_q <= 1'b1;
               end
            end
            S_READY: begin
               if (any_pend) begin
                  state_q   <= S_CHECK;
                  chk_req_q <= 1'b1;
                  chk_op_q  <= sel_op;
               end
            end
            S_CHECK: begin
               if (chk_done) begin
                  chk_req_q <= 1'b0;
                  if (chk_ok) begin
                     state_q  <= S_COMMIT;
                     commit_q <= 1'b1;
                  end else if (chk_op_q == OP_DOWN) begin
                     state_q    <= S_LOCK;
                     lock_req_q <= 1'b1;
                  end else begin
                     state_q <= S_READY;
                  end
               end
            end
            S_COMMIT: begin
               commit_q <= 1'b0;
               state_q  <= S_READY;
            end
            S_LOCK: begin
               if (lock_done) begin
                  lock_req_q  <= 1'b0;
                  spawn_req_q <= 1'b1;
                  state_q     <= S_SPAWN;
               end
            end
            S_OVER: begin
               chk_req_q   <= 1'b0;
               chk_op_q    <= OP_DOWN;
               commit_q    <= 1'b0;
               lock_req_q  <= 1'b0;
               spawn_req_q <= 1'b0;
               game_over_q <= 1'b1;
            end
            default: begin
               state_q <= S_SPAWN;
            end
         endcase
      end
   end

   assign chk_req   = chk_req_q;
   assign chk_op    = chk_op_q;
   assign commit    = commit_q;
   assign lock_req  = lock_req_q;
   assign spawn_req = spawn_req_q;
   assign game_over = game_over_q;

endmodule

// File: tb/tb_tetris_step_sched.sv
// tb/tb_tetris_step_sched.sv - directed bench for tetris_step_sched with a one-cycle datapath responder
module tb_tetris_step_sched;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       key_left = 1'b0, key_right = 1'b0, key_rot = 1'b0, key_down = 1'b0;
   logic       chk_done = 1'b0, chk_ok = 1'b0, lock_done = 1'b0, spawn_done = 1'b0, spawn_ok = 1'b0;
   logic       chk_req, commit, lock_req, spawn_req, game_over;
   logic [1:0] chk_op;

   logic       model_chk_ok = 1'b1;
   logic       model_spawn_ok = 1'b1;

   int         cyc = 0;
   int         n_cmp = 0;
   int         n_bad = 0;

   int         chk_ops[$];
   int         chk_cycs[$];
   int         commit_cnt = 0;
   int         lock_cnt = 0;
   logic       prev_chk = 1'b0;

   tetris_step_sched #(.TICK_DIV(16)) dut (
      .CLOCK_50   (clk),
      .reset      (reset),
      .key_left   (key_left),
      .key_right  (key_right),
      .key_rot    (key_rot),
      .key_down   (key_down),
      .chk_req    (chk_req),
      .chk_op     (chk_op),
      .chk_done   (chk_done),
      .chk_ok     (chk_ok),
      .commit     (commit),
      .lock_req   (lock_req),
      .lock_done  (lock_done),
      .spawn_req  (spawn_req),
      .spawn_done (spawn_done),
      .spawn_ok   (spawn_ok),
      .game_over  (game_over)
   );

   always #5 clk = ~clk;

   // cycle index: value seen at a falling edge equals the number of rising edges so far
   always @(posedge clk) cyc <= cyc + 1;

   // datapath responder: done pulse on the cycle after each request rises
   always @(negedge clk) begin
      chk_done   = chk_req && !chk_done;
      chk_ok     = model_chk_ok;
      lock_done  = lock_req && !lock_done;
      spawn_done = spawn_req && !spawn_done;
      spawn_ok   = model_spawn_ok;
   end

   // event log of check requests, commits and locks
   always @(negedge clk) begin
      if (chk_req && !prev_chk) begin
         chk_ops.push_back(int'(chk_op));
         chk_cycs.push_back(cyc);
      end
      if (commit) commit_cnt++;
      if (lock_req && !dut.lock_req_q) lock_cnt = lock_cnt;
      prev_chk = chk_req;
   end

   task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_chk(input int budget);
      int n0;
      int k;
      n0 = chk_ops.size();
      k  = 0;
      while (chk_ops.size() == n0 && k < budget) begin
         step();
         k++;
      end
      if (chk_ops.size() == n0) expect_eq("wait_chk_timeout", chk_ops.size(), n0 + 1);
   endtask

   function automatic int op_at(input int i);
      if (i < 0 || i >= chk_ops.size()) return -1;
      return chk_ops[i];
   endfunction

   function automatic int cyc_at(input int i);
      if (i < 0 || i >= chk_cycs.size()) return -1;
      return chk_cycs[i];
   endfunction

   // count lock_req rises separately from the DUT-independent log
   logic prev_lock = 1'b0;
   always @(negedge clk) begin
      if (lock_req && !prev_lock) lock_cnt++;
      prev_lock = lock_req;
   end

   initial begin
      int n0, c0, l0, d;

      // reset and first spawn
      repeat (8) step();
      expect_eq("reset_outputs", {26'd0, chk_req, chk_op, commit, lock_req, spawn_req, game_over}, 32'd0);
      reset = 1'b0;
      step();
      expect_eq("spawn_req_first_cycle", spawn_req, 1);
      step();
      expect_eq("spawn_req_dropped", spawn_req, 0);
      expect_eq("game_over_clear", game_over, 0);

      // left key held 10 cycles gives exactly one left pass
      wait_chk(40);
      expect_eq("t2_tick_op", op_at(chk_ops.size() - 1), 0);
      repeat (2) step();
      n0 = chk_ops.size();
      c0 = commit_cnt;
      key_left = 1'b1;
      repeat (10) step();
      key_left = 1'b0;
      step();
      expect_eq("t2_left_checks", chk_ops.size() - n0, 1);
      expect_eq("t2_left_op", op_at(n0), 1);
      expect_eq("t2_left_commits", commit_cnt - c0, 1);

      // left and right together: left first, right on a separate pass
      wait_chk(40);
      repeat (2) step();
      n0 = chk_ops.size();
      c0 = commit_cnt;
      key_left = 1'b1;
      key_right = 1'b1;
      repeat (2) step();
      key_left = 1'b0;
      key_right = 1'b0;
      repeat (7) step();
      expect_eq("t2b_checks", chk_ops.size() - n0, 2);
      expect_eq("t2b_first_op", op_at(n0), 1);
      expect_eq("t2b_second_op", op_at(n0 + 1), 2);
      expect_eq("t2b_commits", commit_cnt - c0, 2);

      // idle gravity: one down check every 16 cycles, each committed
      wait_chk(40);
      n0 = chk_ops.size() - 1;
      c0 = commit_cnt;
      wait_chk(40);
      wait_chk(40);
      repeat (2) step();
      expect_eq("t3_op0", op_at(n0), 0);
      expect_eq("t3_op1", op_at(n0 + 1), 0);
      expect_eq("t3_op2", op_at(n0 + 2), 0);
      expect_eq("t3_period_a", cyc_at(n0 + 1) - cyc_at(n0), 16);
      expect_eq("t3_period_b", cyc_at(n0 + 2) - cyc_at(n0 + 1), 16);
      expect_eq("t3_commits", commit_cnt - c0, 3);

      // key_down pulse at counter value 10 (two cycles after a down check the counter reads 2)
      wait_chk(40);
      n0 = chk_ops.size() - 1;
      d  = cyc_at(n0);
      repeat (8) step();
      key_down = 1'b1;
      step();
      key_down = 1'b0;
      wait_chk(40);
      expect_eq("t6_down_op", op_at(n0 + 1), 0);
`ifdef SOFT_DROP_EN
      // sampled at d+9, edge seen and counter reloaded at d+10, check at d+11; wrap 16 later at d+26, check d+28
      expect_eq("t6_soft_latency", cyc_at(n0 + 1) - d, 11);
      wait_chk(40);
      expect_eq("t6_soft_next_tick", cyc_at(n0 + 2) - cyc_at(n0 + 1), 17);
`else
      expect_eq("t6_key_down_ignored", cyc_at(n0 + 1) - d, 16);
`endif

      // rotate and right rise together with the tick pend: order down, rotate, right
      wait_chk(40);
      n0 = chk_ops.size() - 1;
      repeat (13) step();
      key_rot = 1'b1;
      key_right = 1'b1;
      repeat (3) step();
      key_rot = 1'b0;
      key_right = 1'b0;
      wait_chk(40);
      wait_chk(40);
      expect_eq("t4_op_down", op_at(n0 + 1), 0);
      expect_eq("t4_op_rot", op_at(n0 + 2), 3);
      expect_eq("t4_op_right", op_at(n0 + 3), 2);
      expect_eq("t4_min_pass", cyc_at(n0 + 2) - cyc_at(n0 + 1), 3);
      expect_eq("t4_tick_latency", cyc_at(n0 + 1) - cyc_at(n0), 16);

      // rejected move is discarded: no commit, no lock
      model_chk_ok = 1'b0;
      repeat (2) step();
      n0 = chk_ops.size();
      c0 = commit_cnt;
      l0 = lock_cnt;
      key_left = 1'b1;
      repeat (2) step();
      key_left = 1'b0;
      repeat (3) step();
      expect_eq("t4b_checks", chk_ops.size() - n0, 1);
      expect_eq("t4b_op", op_at(n0), 1);
      expect_eq("t4b_no_commit", commit_cnt - c0, 0);
      expect_eq("t4b_no_lock", lock_cnt - l0, 0);
      expect_eq("t4b_chk_req_low", chk_req, 0);

      // rejected down locks, spawn fails, game over
      model_spawn_ok = 1'b0;
      wait_chk(40);
      expect_eq("t5_down_op", op_at(chk_ops.size() - 1), 0);
      step();
      expect_eq("t5_lock_req", {lock_req, chk_req, commit}, 3'b100);
      step();
      expect_eq("t5_spawn_after_lock", {lock_req, spawn_req}, 2'b01);
      step();
      expect_eq("t5_game_over", {game_over, spawn_req}, 2'b10);
      n0 = chk_ops.size();
      for (int i = 0; i < 40; i++) begin
         key_left  = (i % 4) == 1;
         key_right = (i % 6) == 2;
         key_rot   = (i % 5) == 3;
         key_down  = (i % 7) == 4;
         step();
      end
      key_left = 1'b0;
      key_right = 1'b0;
      key_rot = 1'b0;
      key_down = 1'b0;
      expect_eq("t5_no_checks_in_over", chk_ops.size() - n0, 0);
      expect_eq("t5_over_outputs", {chk_req, chk_op, commit, lock_req, spawn_req, game_over}, 7'b0000001);

      // reset leaves game over and restarts with a spawn
      model_spawn_ok = 1'b1;
      model_chk_ok = 1'b1;
      reset = 1'b1;
      repeat (2) step();
      expect_eq("t5_reset_outputs", {chk_req, chk_op, commit, lock_req, spawn_req, game_over}, 7'b0);
      reset = 1'b0;
      step();
      expect_eq("t5_respawn_req", spawn_req, 1);
      step();
      expect_eq("t5_respawn_done", {spawn_req, game_over}, 2'b00);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
